memory_writer: RTL and testbench

Avalon-ST sink to on-chip RAM writer for the DSP/DFT sample path. Once armed, it accepts one packet framed by sop/eop on its stream sink and writes each beat to consecutive RAM words starting at address 0 through a write-only Avalon-MM style port. It reports the packet length and any length error, so software or the downstream DFT engine can consume a complete frame from memory.

---
 rtl/memory_writer_if.sv | 52 +++++
 rtl/memory_writer.sv | 133 +++++++++++++
 tb/tb_memory_writer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_writer_if.sv
// Stream sink, RAM write port and status bundle for memory_writer.
// The slave modport is the writer's view; the master modport is the producer/consumer view.
interface memory_writer_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic              memory_writer_arm;
    logic [ADDR_W-1:0] memory_writer_writeaddress;
    logic              memory_writer_write;
    logic [DATA_W-1:0] memory_writer_writedata;
    logic [1:0]        memory_writer_status;
    logic [13:0]       memory_writer_count;
    logic              memory_writer_error;
    logic              memory_writer_done;
    logic [DATA_W-1:0] memory_writer_sink_data;
    logic              memory_writer_sink_valid;
    logic              memory_writer_sink_sop;
    logic              memory_writer_sink_eop;
    logic              memory_writer_sink_ready;

    modport slave (
        input  memory_writer_arm,
        input  memory_writer_sink_data,
        input  memory_writer_sink_valid,
        input  memory_writer_sink_sop,
        input  memory_writer_sink_eop,
        output memory_writer_writeaddress,
        output memory_writer_write,
        output memory_writer_writedata,
        output memory_writer_status,
        output memory_writer_count,
        output memory_writer_error,
        output memory_writer_done,
        output memory_writer_sink_ready
    );

    modport master (
        output memory_writer_arm,
        output memory_writer_sink_data,
        output memory_writer_sink_valid,
        output memory_writer_sink_sop,
        output memory_writer_sink_eop,
        input  memory_writer_writeaddress,
        input  memory_writer_write,
        input  memory_writer_writedata,
        input  memory_writer_status,
        input  memory_writer_count,
        input  memory_writer_error,
        input  memory_writer_done,
        input  memory_writer_sink_ready
    );
endinterface

// File: rtl/memory_writer.sv
// Captures one sop/eop-framed stream packet into RAM words 0..DEPTH-1 once armed,
// reporting word count, a sticky length error and a done pulse.
module memory_writer #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    memory_writer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOP = 2'd1,
        RECEIVE  = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [13:0] DEPTH_C = 14'(DEPTH);

    state_t      r_state;
    logic [13:0] r_count;
    logic        r_error;
    logic        r_done;

    state_t            w_state_next;
    logic [13:0]       w_count_next;
    logic [13:0]       w_count_inc;
    logic              w_error_next;
    logic              w_done_next;
    logic              w_ready;
    logic              w_accept;
    logic              w_write;
    logic [ADDR_W-1:0] w_addr;

    assign w_ready     = (r_state != IDLE);
    assign w_accept    = bus.memory_writer_sink_valid & w_ready;
    assign w_count_inc = r_count + 14'd1;

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_error_next = r_error;
        w_done_next  = 1'b0;
        w_write      = 1'b0;
        w_addr       = '0;
        case (r_state)
            IDLE: begin
                if (bus.memory_writer_arm) begin
                    w_state_next = WAIT_SOP;
                    w_count_next = '0;
                    w_error_next = 1'b0;
                end
            end
            WAIT_SOP: begin
                if (w_accept && bus.memory_writer_sink_sop) begin
                    w_write      = 1'b1;
                    w_count_next = 14'd1;
                    if (bus.memory_writer_sink_eop) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                        w_error_next = (DEPTH != 1);
                    end else begin
                        w_state_next = RECEIVE;
                    end
                end
            end
            RECEIVE: begin
                if (w_accept) begin
                    // A fresh sop restarts the frame at word 0 even after overflow.
                    if (bus.memory_writer_sink_sop) begin
                        w_error_next = 1'b1;
                        w_write      = 1'b1;
                        w_count_next = 14'd1;
                        if (bus.memory_writer_sink_eop) begin
                            w_state_next = IDLE;
                            w_done_next  = 1'b1;
                        end
                    end else if (r_count == DEPTH_C) begin
                        w_error_next = 1'b1;
                        if (bus.memory_writer_sink_eop) begin
                            w_state_next = IDLE;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = FLUSH;
                        end
                    end else begin
                        w_write      = 1'b1;
                        w_addr       = ADDR_W'(r_count);
                        w_count_next = w_count_inc;
                        if (bus.memory_writer_sink_eop) begin
                            w_state_next = IDLE;
                            w_done_next  = 1'b1;
                            if (w_count_inc != DEPTH_C) begin
                                w_error_next = 1'b1;
                            end
                        end
                    end
                end
            end
            FLUSH: begin
                if (w_accept && bus.memory_writer_sink_eop) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_error <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_error <= w_error_next;
            r_done  <= w_done_next;
        end
    end

    assign bus.memory_writer_write        = w_write;
    assign bus.memory_writer_writeaddress = w_write ? w_addr : '0;
    assign bus.memory_writer_writedata    = w_write ? bus.memory_writer_sink_data : '0;
    assign bus.memory_writer_status       = r_state;
    assign bus.memory_writer_count        = r_count;
    assign bus.memory_writer_error        = r_error;
    assign bus.memory_writer_done         = r_done;
    assign bus.memory_writer_sink_ready   = w_ready;
endmodule

// File: tb/tb_memory_writer.sv
// Directed packet scenarios for memory_writer, checked every cycle against a
// behavioural frame-capture model plus literal per-packet expectations.
module tb_memory_writer;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam logic [31:0] SENT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    memory_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_wr  = 0;

    logic [31:0] tb_ram [DEPTH];
    logic [31:0] m_ram  [DEPTH];

    // Model: phase mirrors the reported status code, cnt is words captured.
    int m_ph = 0, m_cnt = 0;
    bit m_err = 0, m_done = 0;
    int nx_ph = 0, nx_cnt = 0;
    bit nx_err = 0, nx_done = 0;
    bit x_we = 0;
    int x_addr = 0;
    logic [31:0] x_wd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit acc, s, e;
        s   = bus.memory_writer_sink_sop;
        e   = bus.memory_writer_sink_eop;
        acc = bus.memory_writer_sink_valid && (m_ph != 0);
        nx_ph = m_ph; nx_cnt = m_cnt; nx_err = m_err; nx_done = 0;
        x_we = 0; x_addr = 0; x_wd = '0;
        case (m_ph)
            0: if (bus.memory_writer_arm) begin nx_ph = 1; nx_cnt = 0; nx_err = 0; end
            1: if (acc && s) begin
                x_we = 1; nx_cnt = 1;
                if (e) begin nx_ph = 0; nx_done = 1; nx_err = (DEPTH != 1); end
                else nx_ph = 2;
            end
            2: if (acc) begin
                if (s) begin
                    nx_err = 1; x_we = 1; nx_cnt = 1;
                    if (e) begin nx_ph = 0; nx_done = 1; end
                end else if (m_cnt == DEPTH) begin
                    nx_err = 1; nx_ph = e ? 0 : 3; nx_done = e;
                end else begin
                    x_we = 1; x_addr = m_cnt; nx_cnt = m_cnt + 1;
                    if (e) begin nx_ph = 0; nx_done = 1; nx_err = m_err | (nx_cnt != DEPTH); end
                end
            end
            default: if (acc && e) begin nx_ph = 0; nx_done = 1; end
        endcase
        if (x_we) x_wd = bus.memory_writer_sink_data;
        chk("ready",  32'(bus.memory_writer_sink_ready), 32'(m_ph != 0));
        chk("write",  32'(bus.memory_writer_write), 32'(x_we));
        chk("waddr",  32'(bus.memory_writer_writeaddress), 32'(x_addr));
        chk("wdata",  bus.memory_writer_writedata, x_wd);
        chk("status", 32'(bus.memory_writer_status), 32'(m_ph));
        chk("count",  32'(bus.memory_writer_count), 32'(m_cnt));
        chk("error",  32'(bus.memory_writer_error), 32'(m_err));
        chk("done",   32'(bus.memory_writer_done), 32'(m_done));
    end

    always @(posedge clk) begin
        if (bus.memory_writer_write === 1'b1) begin
            n_wr++;
            if (int'(bus.memory_writer_writeaddress) < DEPTH)
                tb_ram[bus.memory_writer_writeaddress] = bus.memory_writer_writedata;
        end
        if (rst) begin
            m_ph = 0; m_cnt = 0; m_err = 0; m_done = 0;
        end else begin
            if (x_we) m_ram[x_addr] = x_wd;
            m_ph = nx_ph; m_cnt = nx_cnt; m_err = nx_err; m_done = nx_done;
        end
    end

    task automatic drv(input bit a, input bit v, input bit s, input bit e,
                       input logic [31:0] d, input bit r);
        bus.memory_writer_arm        = a;
        bus.memory_writer_sink_valid = v;
        bus.memory_writer_sink_sop   = s;
        bus.memory_writer_sink_eop   = e;
        bus.memory_writer_sink_data  = d;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < DEPTH; i++) begin
            tb_ram[i] = SENT;
            m_ram[i]  = SENT;
        end
        n_wr = 0;
    endtask

    task automatic cmp_ram(input string name);
        for (int i = 0; i < DEPTH; i++) chk(name, tb_ram[i], m_ram[i]);
    endtask

    // n beats, extra sop at beat sop2, optional gaps, garbage beats before sop,
    // arm pulse at beat arm_at, reset instead of beat rst_at, tail idle cycles.
    task automatic run_pkt(input string name, input int n, input int sop2, input bit gap,
                           input int garbage, input int arm_at, input bit chk_flush,
                           input int rst_at, input int tail);
        clear_ram();
        drv(1, 0, 0, 0, '0, 0);
        chk({name, "_arm_status"}, 32'(bus.memory_writer_status), 32'd1);
        chk({name, "_arm_count"},  32'(bus.memory_writer_count), 32'd0);
        chk({name, "_arm_error"},  32'(bus.memory_writer_error), 32'd0);
        for (int g = 0; g < garbage; g++) drv(0, 1, 0, 0, 32'hBAD0_0000 + 32'(g), 0);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                drv(0, 0, 0, 0, '0, 1);
                chk({name, "_rst_status"}, 32'(bus.memory_writer_status), 32'd0);
                chk({name, "_rst_ready"},  32'(bus.memory_writer_sink_ready), 32'd0);
                drv(0, 0, 0, 0, '0, 0);
                chk({name, "_rst_nwr"}, 32'(n_wr), 32'(rst_at));
                $display("packet %s: reset after %0d beats", name, rst_at);
                return;
            end
            drv(i == arm_at, 1, (i == 0) || (i == sop2), i == n - 1, 32'(i), 0);
            if (chk_flush && i >= DEPTH && i < n - 1)
                chk({name, "_flush_status"}, 32'(bus.memory_writer_status), 32'd3);
            if (gap && i < n - 1) drv(0, 0, 0, 0, 32'h5A5A_5A5A, 0);
        end
        chk({name, "_done"}, 32'(bus.memory_writer_done), 32'd1);
        if (tail > 0) begin
            repeat (tail) drv(0, 0, 0, 0, '0, 0);
            chk({name, "_done_low"}, 32'(bus.memory_writer_done), 32'd0);
            chk({name, "_idle"}, 32'(bus.memory_writer_status), 32'd0);
        end
        cmp_ram({name, "_ram"});
        $display("packet %s: beats=%0d writes=%0d count=%0d error=%0b",
                 name, n, n_wr, bus.memory_writer_count, bus.memory_writer_error);
    endtask

    initial begin
        bus.memory_writer_arm = 0; bus.memory_writer_sink_valid = 0;
        bus.memory_writer_sink_sop = 0; bus.memory_writer_sink_eop = 0;
        bus.memory_writer_sink_data = '0;
        repeat (3) drv(0, 0, 0, 0, '0, 1);
        chk("reset_status", 32'(bus.memory_writer_status), 32'd0);
        chk("reset_count",  32'(bus.memory_writer_count), 32'd0);
        chk("reset_ready",  32'(bus.memory_writer_sink_ready), 32'd0);
        chk("reset_write",  32'(bus.memory_writer_write), 32'd0);
        drv(0, 0, 0, 0, '0, 0);

        run_pkt("nominal", 1024, -1, 0, 0, -1, 0, -1, 2);
        chk("nominal_count", 32'(bus.memory_writer_count), 32'd1024);
        chk("nominal_error", 32'(bus.memory_writer_error), 32'd0);
        chk("nominal_nwr", 32'(n_wr), 32'd1024);
        for (int i = 0; i < DEPTH; i++) chk("nominal_data", tb_ram[i], 32'(i));

        run_pkt("gapped_arm", 1024, -1, 1, 0, 300, 0, -1, 2);
        chk("gapped_count", 32'(bus.memory_writer_count), 32'd1024);
        chk("gapped_error", 32'(bus.memory_writer_error), 32'd0);
        chk("gapped_nwr", 32'(n_wr), 32'd1024);
        for (int i = 0; i < DEPTH; i++) chk("gapped_data", tb_ram[i], 32'(i));

        run_pkt("garbage", 1024, -1, 0, 3, -1, 0, -1, 2);
        chk("garbage_nwr", 32'(n_wr), 32'd1024);
        chk("garbage_first", tb_ram[0], 32'd0);
        chk("garbage_error", 32'(bus.memory_writer_error), 32'd0);

        run_pkt("short", 10, -1, 0, 0, -1, 0, -1, 0);
        chk("short_count", 32'(bus.memory_writer_count), 32'd10);
        chk("short_error", 32'(bus.memory_writer_error), 32'd1);
        chk("short_nwr", 32'(n_wr), 32'd10);

        run_pkt("b2b", 1024, -1, 0, 0, -1, 0, -1, 2);
        chk("b2b_error", 32'(bus.memory_writer_error), 32'd0);

        run_pkt("long", 1030, -1, 0, 0, -1, 1, -1, 2);
        chk("long_count", 32'(bus.memory_writer_count), 32'd1024);
        chk("long_error", 32'(bus.memory_writer_error), 32'd1);
        chk("long_nwr", 32'(n_wr), 32'd1024);
        chk("long_last", tb_ram[1023], 32'd1023);

        run_pkt("midsop", 1024, 5, 0, 0, -1, 0, -1, 2);
        chk("midsop_count", 32'(bus.memory_writer_count), 32'd1019);
        chk("midsop_error", 32'(bus.memory_writer_error), 32'd1);
        chk("midsop_addr0", tb_ram[0], 32'd5);
        chk("midsop_last", tb_ram[1018], 32'd1023);
        chk("midsop_nwr", 32'(n_wr), 32'd1024);

        run_pkt("reset", 1024, -1, 0, 0, -1, 0, 500, 2);
        chk("reset_keep", tb_ram[499], 32'd499);
        run_pkt("after_rst", 1024, -1, 0, 0, -1, 0, -1, 2);
        chk("after_rst_count", 32'(bus.memory_writer_count), 32'd1024);
        chk("after_rst_error", 32'(bus.memory_writer_error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
